// File: rtl/store_seq_checker.sv
// store_seq_checker
//   Self-test monitor for the core's data-memory write port. It compares each
//   store (mem_write/data_adr/write_data) against a programmable, ordered table
//   of expected {address, data} pairs. Stores to IGNORE_ADDR that do not match
//   the current entry can be skipped. A RUN window is bounded by TIMEOUT_CYC
//   sampled cycles. The first offending store is captured.
//
// Ports
//   clk, reset                 rising-edge clock, async active-low reset
//   mem_write/data_adr/
//   write_data                 core store port being monitored
//   cfg_we/cfg_idx/
//   cfg_addr/cfg_data          table write port, ignored while RUN
//   exp_len                    entries to check, sampled on start
//   start                      arm/restart the checker from any state
//   busy/done/pass             RUN / terminal / all entries matched
//   fail_code                  0 none, 1 mismatch, 2 timeout
//   match_count, ignore_count  progress counters; ignore_count saturates
//   fail_addr, fail_data       the offending store
module store_seq_checker #(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        NUM_EXP     = 4,
    parameter int unsigned        TIMEOUT_CYC = 200,
    parameter bit                 IGNORE_EN   = 1'b1,
    parameter logic [ADDR_W-1:0]  IGNORE_ADDR = ADDR_W'(96),
    localparam int unsigned       IW          = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
    localparam int unsigned       CW          = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CW-1:0]     exp_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [1:0]        fail_code,
    output logic [CW-1:0]     match_count,
    output logic [7:0]        ignore_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        PASS = 3'd2,
        FAIL = 3'd3,
        TMO  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] tab_addr_q [NUM_EXP];
    logic [ADDR_W-1:0] tab_addr_d [NUM_EXP];
    logic [DATA_W-1:0] tab_data_q [NUM_EXP];
    logic [DATA_W-1:0] tab_data_d [NUM_EXP];
    logic [CW-1:0]     len_q, len_d;
    // match_count doubles as the table index: both start at 0 and advance together.
    logic [CW-1:0]     match_count_q, match_count_d;
    logic [TW-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [7:0]        ignore_count_q, ignore_count_d;
    logic [1:0]        fail_code_q, fail_code_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [CW-1:0]     len_clamped;
    logic              hit;

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int unsigned i = 0; i < NUM_EXP; i++) begin
            if (match_count_q == CW'(i)) begin
                cur_addr = tab_addr_q[i];
                cur_data = tab_data_q[i];
            end
        end
    end

    assign hit         = mem_write && (data_adr == cur_addr) && (write_data == cur_data);
    assign len_clamped = (exp_len > CW'(NUM_EXP)) ? CW'(NUM_EXP) : exp_len;

    always_comb begin
        state_d        = state_q;
        tab_addr_d     = tab_addr_q;
        tab_data_d     = tab_data_q;
        len_d          = len_q;
        match_count_d  = match_count_q;
        cycle_cnt_d    = cycle_cnt_q;
        ignore_count_d = ignore_count_q;
        fail_code_d    = fail_code_q;
        fail_addr_d    = fail_addr_q;
        fail_data_d    = fail_data_q;

        // Out-of-range cfg_idx simply matches no entry.
        if (cfg_we && (state_q != RUN)) begin
            for (int unsigned i = 0; i < NUM_EXP; i++) begin
                if (cfg_idx == IW'(i)) begin
                    tab_addr_d[i] = cfg_addr;
                    tab_data_d[i] = cfg_data;
                end
            end
        end

        if (start) begin
            len_d          = len_clamped;
            match_count_d  = '0;
            cycle_cnt_d    = '0;
            ignore_count_d = '0;
            fail_code_d    = 2'd0;
            fail_addr_d    = '0;
            fail_data_d    = '0;
            state_d        = (len_clamped == '0) ? PASS : RUN;
        end else if (state_q == RUN) begin
            if (hit) begin
                match_count_d = match_count_q + 1'b1;
                if (match_count_d == len_q) begin
                    state_d = PASS;
                end
            end else if (mem_write && IGNORE_EN && (data_adr == IGNORE_ADDR)) begin
                if (ignore_count_q != 8'hFF) begin
                    ignore_count_d = ignore_count_q + 1'b1;
                end
            end else if (mem_write) begin
                fail_addr_d = data_adr;
                fail_data_d = write_data;
                fail_code_d = 2'd1;
                state_d     = FAIL;
            end

            // Timeout only when the store above did not already end the run,
            // so a deciding store on the last cycle wins.
            if (state_d == RUN) begin
                if (cycle_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    fail_code_d = 2'd2;
                    state_d     = TMO;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            match_count_q  <= '0;
            cycle_cnt_q    <= '0;
            ignore_count_q <= '0;
            fail_code_q    <= '0;
            fail_addr_q    <= '0;
            fail_data_q    <= '0;
            for (int unsigned i = 0; i < NUM_EXP; i++) begin
                tab_addr_q[i] <= '0;
                tab_data_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            match_count_q  <= match_count_d;
            cycle_cnt_q    <= cycle_cnt_d;
            ignore_count_q <= ignore_count_d;
            fail_code_q    <= fail_code_d;
            fail_addr_q    <= fail_addr_d;
            fail_data_q    <= fail_data_d;
            tab_addr_q     <= tab_addr_d;
            tab_data_q     <= tab_data_d;
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == PASS) || (state_q == FAIL) || (state_q == TMO);
    assign pass         = (state_q == PASS);
    assign fail_code    = fail_code_q;
    assign match_count  = match_count_q;
    assign ignore_count = ignore_count_q;
    assign fail_addr    = fail_addr_q;
    assign fail_data    = fail_data_q;

endmodule

// File: tb/tb_store_seq_checker.sv
module tb_store_seq_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  exp_len;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [2:0]  match_count;
    logic [7:0]  ignore_count;
    logic [31:0] fail_addr;
    logic [31:0] fail_data;

    store_seq_checker #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .NUM_EXP     (4),
        .TIMEOUT_CYC (10),
        .IGNORE_EN   (1'b1),
        .IGNORE_ADDR (32'd96)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_write    (mem_write),
        .data_adr     (data_adr),
        .write_data   (write_data),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .exp_len      (exp_len),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail_code    (fail_code),
        .match_count  (match_count),
        .ignore_count (ignore_count),
        .fail_addr    (fail_addr),
        .fail_data    (fail_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pass;
        logic [1:0]  code;
        logic [2:0]  mc;
        logic [7:0]  ic;
        logic [31:0] fa;
        logic [31:0] fd;
    } exp_t;

    typedef struct {
        int               n_tbl;
        logic [3:0][31:0] t_addr;
        logic [3:0][31:0] t_data;
        logic [2:0]       len;
        int               n_st;
        logic [5:0][31:0] s_addr;
        logic [5:0][31:0] s_data;
        exp_t             e;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    vec_t vecs[8];

    function automatic logic [3:0][31:0] p4(int a0, int a1, int a2, int a3);
        return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic logic [5:0][31:0] p6(int a0, int a1, int a2, int a3);
        return {32'd0, 32'd0, 32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    endfunction

    function automatic exp_t mke(string nm, logic p, logic [1:0] c, int mc, int ic, int fa, int fd);
        exp_t e;
        e.name = nm; e.pass = p; e.code = c;
        e.mc = 3'(mc); e.ic = 8'(ic); e.fa = 32'(fa); e.fd = 32'(fd);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int i, input int a, input int d);
        cfg_we = 1'b1; cfg_idx = 2'(i); cfg_addr = 32'(a); cfg_data = 32'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic arm(input int len);
        exp_len = 3'(len); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input int a, input int d);
        mem_write = 1'b1; data_adr = 32'(a); write_data = 32'(d);
        tick();
        mem_write = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   b;
        for (int i = 0; i < v.n_tbl; i++) load_entry(i, int'(v.t_addr[i]), int'(v.t_data[i]));
        sb_q.push_back(v.e);
        arm(int'(v.len));
        for (int k = 0; k < v.n_st; k++) store(int'(v.s_addr[k]), int'(v.s_data[k]));
        b = 0;
        while (!done && b < 30) begin
            tick();
            b++;
        end
        e = sb_q.pop_front();
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_done_wait actual=0 required=1", e.name);
        end else begin
            chk({e.name, "_pass"}, 32'(pass), 32'(e.pass));
            chk({e.name, "_code"}, 32'(fail_code), 32'(e.code));
            chk({e.name, "_mc"}, 32'(match_count), 32'(e.mc));
            chk({e.name, "_ic"}, 32'(ignore_count), 32'(e.ic));
            chk({e.name, "_faddr"}, fail_addr, e.fa);
            chk({e.name, "_fdata"}, fail_data, e.fd);
        end
    endtask

    initial begin
        vecs[0] = '{1, p4(100,0,0,0), p4(25,0,0,0), 3'd1, 2, p6(96,100,0,0), p6(7,25,0,0),
                    mke("ign_then_pass", 1, 0, 1, 1, 0, 0)};
        vecs[1] = '{3, p4(100,104,108,0), p4(25,7,9,0), 3'd3, 2, p6(100,104,0,0), p6(25,8,0,0),
                    mke("mismatch_2nd", 0, 1, 1, 0, 104, 8)};
        vecs[2] = '{3, p4(100,104,108,0), p4(25,7,9,0), 3'd3, 4, p6(100,96,104,108), p6(25,1,7,9),
                    mke("pass3_ign", 1, 0, 3, 1, 0, 0)};
        vecs[3] = '{4, p4(100,104,108,112), p4(1,2,3,4), 3'd7, 4, p6(100,104,108,112), p6(1,2,3,4),
                    mke("len_clamp", 1, 0, 4, 0, 0, 0)};
        vecs[4] = '{1, p4(96,0,0,0), p4(5,0,0,0), 3'd1, 2, p6(96,96,0,0), p6(4,5,0,0),
                    mke("entry_at_ign", 1, 0, 1, 1, 0, 0)};
        vecs[5] = '{1, p4(100,0,0,0), p4(25,0,0,0), 3'd1, 1, p6(200,0,0,0), p6(1,0,0,0),
                    mke("mismatch_1st", 0, 1, 0, 0, 200, 1)};
        vecs[6] = '{1, p4(100,0,0,0), p4(25,0,0,0), 3'd1, 0, p6(0,0,0,0), p6(0,0,0,0),
                    mke("timeout", 0, 2, 0, 0, 0, 0)};
        vecs[7] = '{0, p4(0,0,0,0), p4(0,0,0,0), 3'd0, 0, p6(0,0,0,0), p6(0,0,0,0),
                    mke("len_zero", 1, 0, 0, 0, 0, 0)};

        reset = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        exp_len = '0; start = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_code", 32'(fail_code), 0);
        chk("rst_mc", 32'(match_count), 0);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Timeout lands exactly 10 edges after RUN entry.
        load_entry(0, 100, 25);
        arm(1);
        chk("tmo_busy", 32'(busy), 1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            if (j == 9) chk("tmo_done_e9", 32'(done), 0);
        end
        chk("tmo_done_e10", 32'(done), 1);
        chk("tmo_code_e10", 32'(fail_code), 2);
        chk("tmo_pass_e10", 32'(pass), 0);

        // Completing store on the timeout edge wins.
        arm(1);
        for (int j = 1; j <= 9; j++) tick();
        store(100, 25);
        chk("edge10_pass", 32'(pass), 1);
        chk("edge10_code", 32'(fail_code), 0);

        // Same store one edge later is too late.
        arm(1);
        for (int j = 1; j <= 10; j++) tick();
        store(100, 25);
        chk("edge11_code", 32'(fail_code), 2);
        chk("edge11_mc", 32'(match_count), 0);

        // Mismatch on the timeout edge reports mismatch.
        arm(1);
        for (int j = 1; j <= 9; j++) tick();
        store(200, 1);
        chk("edge10_mm_code", 32'(fail_code), 1);
        chk("edge10_mm_addr", fail_addr, 200);

        // Restart from FAIL with a table rewrite, and cfg_we during RUN ignored.
        run_vec(vecs[1]);
        load_entry(1, 104, 8);
        arm(3);
        chk("rst_fail_busy", 32'(busy), 1);
        chk("rst_fail_code", 32'(fail_code), 0);
        chk("rst_fail_faddr", fail_addr, 0);
        chk("rst_fail_fdata", fail_data, 0);
        load_entry(1, 104, 99);
        store(100, 25);
        store(104, 8);
        store(108, 9);
        chk("rst_fail_pass", 32'(pass), 1);
        chk("rst_fail_mc", 32'(match_count), 3);

        // Reset mid-RUN after one match.
        load_entry(0, 100, 25);
        load_entry(1, 104, 7);
        arm(2);
        store(100, 25);
        chk("mid_mc", 32'(match_count), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_pass", 32'(pass), 0);
        chk("mid_rst_mc", 32'(match_count), 0);
        chk("mid_rst_code", 32'(fail_code), 0);
        #1;
        reset = 1'b1;
        arm(0);
        chk("post_rst_done", 32'(done), 1);
        chk("post_rst_pass", 32'(pass), 1);
        // Table was cleared by reset: entry 0 is now (0,0).
        arm(1);
        store(0, 0);
        chk("tbl_cleared_pass", 32'(pass), 1);
        chk("tbl_cleared_mc", 32'(match_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
